sram_burst_ctrl: RTL and testbench

Burst access controller that sits directly upstream of the cache `sram` macro and is its only driver. It accepts a burst request (start row, length, direction) on a valid/ready port. It then sequences `REN`/`WEN`/`SEL`/`wVal` into the SRAM one row per cycle. Write beats are streamed in from a valid/ready write-data port. Read beats are returned through a registered valid/ready read-data port.

---
 rtl/sram_burst_ctrl.sv | 133 +++++++++++++
 tb/tb_sram_burst_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_ctrl
// Purpose  : Burst sequencer driving a single-port cache SRAM, one row per
//            cycle, with streamed write beats and a registered read port.
// Revision : 1.0
// ============================================================================
module sram_burst_ctrl #(
    parameter int SRAM_WR_SIZE = 128,
    parameter int SRAM_HEIGHT  = 128,
    parameter int MAX_BURST    = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [$clog2(SRAM_HEIGHT):0]  req_addr,
    input  logic [$clog2(MAX_BURST)-1:0]  req_len,
    input  logic                          wdata_valid,
    output logic                          wdata_ready,
    input  logic [SRAM_WR_SIZE-1:0]       wdata,
    output logic                          rdata_valid,
    input  logic                          rdata_ready,
    output logic [SRAM_WR_SIZE-1:0]       rdata,
    output logic                          rdata_last,
    output logic                          busy,
    output logic                          err,
    output logic                          sram_REN,
    output logic                          sram_WEN,
    output logic [$clog2(SRAM_HEIGHT):0]  sram_SEL,
    output logic [SRAM_WR_SIZE-1:0]       sram_wVal,
    input  logic [SRAM_WR_SIZE-1:0]       sram_rVal
);

    localparam int AW = $clog2(SRAM_HEIGHT) + 1;
    localparam int LW = $clog2(MAX_BURST);

    localparam logic [AW-1:0] c_HEIGHT   = AW'(SRAM_HEIGHT);
    localparam logic [AW-1:0] c_LAST_ROW = AW'(SRAM_HEIGHT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WR   = 2'd1;
    localparam logic [1:0] c_RD   = 2'd2;

    logic [1:0]              r_state, w_state_nxt;
    logic [AW-1:0]           r_addr, w_addr_nxt, w_addr_inc;
    logic [LW-1:0]           r_beats_left, w_beats_nxt;
    logic [SRAM_WR_SIZE-1:0] r_rdata;
    logic                    r_rdata_valid;
    logic                    r_rdata_last;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_illegal;
    logic                    w_issue;

    assign w_accept   = req_valid && (r_state == c_IDLE);
    assign w_illegal  = (req_addr >= c_HEIGHT);
    // A read may issue whenever the output register is empty or draining now.
    assign w_issue    = (r_state == c_RD) && (!r_rdata_valid || rdata_ready);
    assign w_addr_inc = (r_addr == c_LAST_ROW) ? '0 : r_addr + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_beats_nxt = r_beats_left;
        sram_WEN    = 1'b0;
        sram_REN    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_addr_nxt  = req_addr;
                    w_beats_nxt = req_len;
                    w_state_nxt = req_write ? c_WR : c_RD;
                end
            end
            c_WR, c_RD: begin
                if ((r_state == c_WR) ? wdata_valid : w_issue) begin
                    sram_WEN = (r_state == c_WR);
                    sram_REN = (r_state == c_RD);
                    if (r_beats_left == '0) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_beats_nxt = r_beats_left - 1'b1;
                        w_addr_nxt  = w_addr_inc;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= c_IDLE;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_beats_left <= w_beats_nxt;
            r_err        <= w_accept && w_illegal;
        end
    end

    // Output register keeps draining in IDLE so a new request can overlap it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
        end else if (w_issue) begin
            r_rdata       <= sram_rVal;
            r_rdata_valid <= 1'b1;
            r_rdata_last  <= (r_beats_left == '0);
        end else if (r_rdata_valid && rdata_ready) begin
            r_rdata_valid <= 1'b0;
        end
    end

    assign req_ready   = (r_state == c_IDLE);
    assign busy        = (r_state != c_IDLE);
    assign wdata_ready = (r_state == c_WR);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign rdata_last  = r_rdata_last;
    assign err         = r_err;
    assign sram_SEL    = r_addr;
    assign sram_wVal   = wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_burst_ctrl
// Purpose  : Vector table plus random bursts against a row-array model of
//            the SRAM contents and a beat-count view of the burst protocol.
// Revision : 1.0
// ============================================================================
module tb_sram_burst_ctrl;

    localparam int DW = 32;
    localparam int H  = 16;
    localparam int MB = 8;
    localparam int AW = 5;
    localparam int LW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid, rdata_ready, rdata_last;
    logic [DW-1:0] rdata;
    logic          busy, err, sram_REN, sram_WEN;
    logic [AW-1:0] sram_SEL;
    logic [DW-1:0] sram_wVal, sram_rVal;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem  [H];
    logic [DW-1:0] gold [H];
    logic          mem_clr;

    always #5 CLK = ~CLK;

    sram_burst_ctrl #(.SRAM_WR_SIZE(DW), .SRAM_HEIGHT(H), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .busy(busy), .err(err),
        .sram_REN(sram_REN), .sram_WEN(sram_WEN), .sram_SEL(sram_SEL),
        .sram_wVal(sram_wVal), .sram_rVal(sram_rVal)
    );

    // Attached SRAM: combinational read, write at the clock edge.
    assign sram_rVal = (sram_SEL < AW'(H)) ? mem[sram_SEL[3:0]] : '0;
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < H; i++) mem[i] <= '0;
        end else if (sram_WEN && (sram_SEL < AW'(H))) begin
            mem[sram_SEL[3:0]] <= sram_wVal;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic reset_now();
        RST = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_enables", {sram_REN, sram_WEN}, 0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic do_burst(input bit wr, input int addr, input int len, input int vmode,
                            input int rmode, input bit fixed, input bit exp_err, input int abort_at);
        int n, done, issued, consumed, hold, cyc;
        bit v, r, ren_exp;
        logic [DW-1:0] d [MB];
        logic [DW-1:0] expq [MB];
        n = len + 1;
        for (int i = 0; i < n; i++) begin
            d[i]    = fixed ? DW'(32'hA + i) : DW'($urandom);
            expq[i] = gold[(addr + i) % H];
        end
        @(negedge CLK);
        req_valid = 1'b1; req_write = wr; req_addr = AW'(addr); req_len = LW'(len);
        wdata_valid = 1'b0; rdata_ready = 1'b0;
        #1;
        chk("idle_req_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_enables", {sram_REN, sram_WEN}, 0);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        #1;
        chk("err_after_accept", err, exp_err);
        if (addr >= H) begin
            chk("illegal_busy", busy, 0);
            chk("illegal_req_ready", req_ready, 1);
            chk("illegal_enables", {sram_REN, sram_WEN}, 0);
            @(negedge CLK); #1;
            chk("err_one_cycle", err, 0);
            return;
        end
        cyc = 0;
        if (wr) begin
            done = 0;
            while (done < n && cyc < 200) begin
                if (cyc > 0) @(negedge CLK);
                if (abort_at == done) begin
                    reset_now();
                    return;
                end
                v = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                wdata_valid = v; wdata = d[done];
                #1;
                chk("wr_busy", busy, 1);
                chk("wr_req_ready", req_ready, 0);
                chk("wr_wdata_ready", wdata_ready, 1);
                chk("wr_wen", sram_WEN, v);
                chk("wr_ren", sram_REN, 0);
                if (v) begin
                    chk("wr_sel", sram_SEL, (addr + done) % H);
                    chk("wr_wval", sram_wVal, d[done]);
                end
                @(posedge CLK);
                if (v) begin
                    gold[(addr + done) % H] = d[done];
                    done++;
                end
                cyc++;
            end
            if (done < n) begin
                tests++; fails++;
                $display("FAIL wr_timeout: got %0d want %0d beats", done, n);
            end
        end else begin
            issued = 0; consumed = 0; hold = 0;
            while (consumed < n && cyc < 300) begin
                if (cyc > 0) @(negedge CLK);
                if (abort_at >= 0 && issued == abort_at) begin
                    reset_now();
                    return;
                end
                r = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1))
                  : (rmode == 2) ? (cyc % 3 == 0) : 1'b0;
                rdata_ready = r;
                #1;
                ren_exp = (issued < n) && (hold == 0 || r);
                chk("rd_ren", sram_REN, ren_exp);
                chk("rd_wen", sram_WEN, 0);
                chk("rd_busy", busy, issued < n);
                chk("rd_valid", rdata_valid, hold);
                if (ren_exp) chk("rd_sel", sram_SEL, (addr + issued) % H);
                if (hold != 0) begin
                    chk("rd_data", rdata, expq[consumed]);
                    chk("rd_last", rdata_last, consumed == len);
                end
                @(posedge CLK);
                if (hold != 0 && r) begin consumed++; hold = 0; end
                if (ren_exp) begin issued++; hold = 1; end
                cyc++;
            end
            if (consumed < n) begin
                tests++; fails++;
                $display("FAIL rd_timeout: got %0d want %0d beats", consumed, n);
            end
        end
        @(negedge CLK);
        wdata_valid = 1'b0; rdata_ready = 1'b0;
        #1;
        chk("exit_busy", busy, 0);
        chk("exit_req_ready", req_ready, 1);
        chk("exit_rdata_valid", rdata_valid, 0);
        chk("exit_enables", {sram_REN, sram_WEN}, 0);
    endtask

    typedef struct {
        bit wr;
        int addr;
        int len;
        int vmode;
        int rmode;
        bit fixed;
        bit exp_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int a;
        vecs[0] = '{1'b1,  4, 3, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{1'b0,  4, 3, 0, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b0,  4, 3, 0, 2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 14, 3, 0, 0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 14, 3, 0, 0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16, 2, 0, 0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 31, 0, 0, 0, 1'b0, 1'b1};
        vecs[7] = '{1'b1,  0, 7, 1, 0, 1'b0, 1'b0};
        vecs[8] = '{1'b0,  0, 7, 0, 1, 1'b0, 1'b0};

        RST = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        for (int i = 0; i < H; i++) gold[i] = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rdata_valid", rdata_valid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_rdata_last", rdata_last, 0);
        chk("reset_err", err, 0);
        chk("reset_enables", {sram_REN, sram_WEN}, 0);
        @(negedge CLK);
        RST = 1'b0; mem_clr = 1'b0;

        for (int i = 0; i < 9; i++)
            do_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].vmode,
                     vecs[i].rmode, vecs[i].fixed, vecs[i].exp_err, -1);

        // Reset after two of eight write beats, then a normal read.
        do_burst(1'b1, 0, 7, 0, 0, 1'b0, 1'b0, 2);
        do_burst(1'b0, 0, 1, 0, 0, 1'b0, 1'b0, -1);
        // Reset while a read beat is held under backpressure.
        do_burst(1'b0, 0, 3, 0, 3, 1'b0, 1'b0, 1);
        do_burst(1'b0, 2, 1, 0, 0, 1'b0, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(H, 31)) : int'($urandom_range(0, H - 1));
            do_burst(1'($urandom_range(0, 1)), a, int'($urandom_range(0, MB - 1)), 1, 1,
                     1'b0, a >= H, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
